// File: rtl/mem_responder.sv
// mem_responder: byte-serial memory responder for a CPU bus (fetch, load, store).
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   bus_pc, bus_mar, bus_mdr         CPU strobes qualifying bus_data (one at a time)
//   bus_data                         request byte, high byte first
//   req_store, req_byte              transaction kind, sampled on first MAR beat
//   prog_we, prog_addr, prog_data    preload write port, usable in any state
//   ard_receive_ready                idle, a new request may start
//   ard_data_ready                   pulse one cycle before the two response bytes
//   rsp_valid, rsp_data              response byte stream, high byte first
//   error, err_flag                  violation pulse and its sticky copy
module mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_pc,
    input  logic              bus_mar,
    input  logic              bus_mdr,
    input  logic [7:0]        bus_data,
    input  logic              req_store,
    input  logic              req_byte,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    output logic              ard_receive_ready,
    output logic              ard_data_ready,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              error,
    output logic              err_flag
);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] PC_LO    = 4'd1;
    localparam logic [3:0] MAR_LO   = 4'd2;
    localparam logic [3:0] DATA_HI  = 4'd3;
    localparam logic [3:0] DATA_LO  = 4'd4;
    localparam logic [3:0] READ     = 4'd5;
    localparam logic [3:0] RESP_RDY = 4'd6;
    localparam logic [3:0] RESP_HI  = 4'd7;
    localparam logic [3:0] RESP_LO  = 4'd8;

    logic [3:0]        state, nxt;
    logic [15:0]       addr, resp;
    logic [7:0]        wdata_hi;
    logic              store, is_byte, viol, multi, wr;
    logic [2:0]        stb;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       mem [0:(1<<ADDR_W)-1];
    logic              unused_addr;

    assign stb         = {bus_pc, bus_mar, bus_mdr};
    assign multi       = (bus_pc & bus_mar) | (bus_pc & bus_mdr) | (bus_mar & bus_mdr);
    assign idx         = addr[ADDR_W-1:0];
    // upper address bits are latched but deliberately ignored: addresses alias
    assign unused_addr = ^addr[15:ADDR_W];

    always_comb begin
        viol = 1'b0;
        nxt  = IDLE;
        case (state)
            IDLE: begin
                viol = multi | (stb == 3'b001);
                nxt  = viol ? IDLE : bus_pc ? PC_LO : bus_mar ? MAR_LO : IDLE;
            end
            PC_LO: begin
                viol = stb != 3'b100;
                nxt  = viol ? IDLE : READ;
            end
            MAR_LO: begin
                viol = stb != 3'b010;
                nxt  = viol ? IDLE : store ? DATA_HI : READ;
            end
            DATA_HI: begin
                viol = stb != 3'b001;
                nxt  = viol ? IDLE : DATA_LO;
            end
            DATA_LO: begin
                viol = stb != 3'b001;
                nxt  = IDLE;
            end
            // strobes while responding are flagged but do not disturb the response
            READ: begin
                viol = |stb;
                nxt  = RESP_RDY;
            end
            RESP_RDY: begin
                viol = |stb;
                nxt  = RESP_HI;
            end
            RESP_HI: begin
                viol = |stb;
                nxt  = RESP_LO;
            end
            RESP_LO: begin
                viol = |stb;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign wr = (state == DATA_LO) && !viol && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= 16'h0000;
            wdata_hi <= 8'h00;
            resp     <= 16'h0000;
            store    <= 1'b0;
            is_byte  <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state <= nxt;
            if (viol)
                err_flag <= 1'b1;
            if (state == IDLE && !viol && (bus_pc | bus_mar))
                addr[15:8] <= bus_data;
            if (state == IDLE && !viol && bus_mar) begin
                store   <= req_store;
                is_byte <= req_byte;
            end
            if ((state == PC_LO || state == MAR_LO) && !viol)
                addr[7:0] <= bus_data;
            if (state == DATA_HI && !viol)
                wdata_hi <= bus_data;
            if (state == READ)
                resp <= mem[idx];
        end
    end

    // preload write comes last so it wins a same-index collision with a store
    always_ff @(posedge clk) begin
        if (wr)
            mem[idx] <= is_byte ? {mem[idx][15:8], wdata_hi} : {wdata_hi, bus_data};
        if (prog_we)
            mem[prog_addr] <= prog_data;
    end

    assign ard_receive_ready = state == IDLE;
    assign ard_data_ready    = !rst && state == RESP_RDY;
    assign rsp_valid         = !rst && (state == RESP_HI || state == RESP_LO);
    assign rsp_data          = (!rst && state == RESP_HI) ? resp[15:8] :
                               (!rst && state == RESP_LO) ? resp[7:0] : 8'h00;
    assign error             = viol && !rst;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed, table-driven check of mem_responder.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_pc = 1'b0, bus_mar = 1'b0, bus_mdr = 1'b0;
    logic [7:0]  bus_data = 8'h00;
    logic        req_store = 1'b0, req_byte = 1'b0, prog_we = 1'b0;
    logic [7:0]  prog_addr = 8'h00;
    logic [15:0] prog_data = 16'h0000;
    logic        ard_receive_ready, ard_data_ready, rsp_valid, error, err_flag;
    logic [7:0]  rsp_data;

    int compared = 0;
    int mismatched = 0;

    mem_responder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .bus_pc(bus_pc), .bus_mar(bus_mar), .bus_mdr(bus_mdr),
        .bus_data(bus_data), .req_store(req_store), .req_byte(req_byte),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ard_receive_ready(ard_receive_ready), .ard_data_ready(ard_data_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .error(error), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  stb;
        logic [7:0]  data;
        logic        st, by, pw;
        logic [7:0]  pa;
        logic [15:0] pd;
        logic        rr, dr, rv;
        logic [7:0]  rd;
        logic        er, ef;
    } vec_t;

    vec_t q[$];

    localparam logic [2:0] X = 3'b000, P = 3'b100, M = 3'b010, D = 3'b001;

    task automatic add(input logic r, input logic [2:0] s, input logic [7:0] d,
                       input logic st, input logic by, input logic pw,
                       input logic [7:0] pa, input logic [15:0] pd,
                       input logic rr, input logic dr, input logic rv,
                       input logic [7:0] rd, input logic er, input logic ef);
        vec_t v;
        v = '{r, s, d, st, by, pw, pa, pd, rr, dr, rv, rd, er, ef};
        q.push_back(v);
    endtask

    task automatic n(input logic [2:0] s, input logic [7:0] d, input logic st, input logic by,
                     input logic rr, input logic dr, input logic rv, input logic [7:0] rd,
                     input logic er, input logic ef);
        add(1'b0, s, d, st, by, 1'b0, 8'h00, 16'h0000, rr, dr, rv, rd, er, ef);
    endtask

    // READ, RESP_RDY, RESP_HI, RESP_LO cycles of a load/fetch with no strobes
    task automatic resp(input logic [7:0] hi, input logic [7:0] lo, input logic ef);
        n(X, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, ef);
        n(X, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, ef);
        n(X, 8'h00, 0, 0, 0, 0, 1, hi, 0, ef);
        n(X, 8'h00, 0, 0, 0, 0, 1, lo, 0, ef);
    endtask

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s row %0d: got %h expected %h", nm, i, act, exp);
        end
    endtask

    int k;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        add(1, X, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h00, 0, 0);
        add(0, X, 8'h00, 0, 0, 1, 8'h12, 16'hBEEF, 1, 0, 0, 8'h00, 0, 0);
        add(0, X, 8'h00, 0, 0, 1, 8'h03, 16'h1234, 1, 0, 0, 8'h00, 0, 0);
        add(0, X, 8'h00, 0, 0, 1, 8'h07, 16'h7777, 1, 0, 0, 8'h00, 0, 0);
        // fetch 0x0012
        n(P, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(P, 8'h12, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        resp(8'hBE, 8'hEF, 0);
        // store 0xCAFE to 0x0005; req_store only counts on the first beat
        n(M, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h05, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(D, 8'hCA, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(D, 8'hFE, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(M, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h05, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        resp(8'hCA, 8'hFE, 0);
        // byte store 0xAB to 0x0003 (holding 0x1234)
        n(M, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h03, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(D, 8'hAB, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(D, 8'h55, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(M, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h03, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        resp(8'h12, 8'hAB, 0);
        // alias: 0x0112 reads index 0x12
        n(P, 8'h01, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(P, 8'h12, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        resp(8'hBE, 8'hEF, 0);
        // store vs preload collision on index 0x20: preload wins
        n(M, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h20, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(D, 8'hCC, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, D, 8'hCC, 0, 0, 1, 8'h20, 16'h5A5A, 0, 0, 0, 8'h00, 0, 0);
        n(M, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h20, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        resp(8'h5A, 8'h5A, 0);
        // preload during READ of same index returns old data
        n(P, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(P, 8'h12, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(0, X, 8'h00, 0, 0, 1, 8'h12, 16'h1111, 0, 0, 0, 8'h00, 0, 0);
        n(X, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        n(X, 8'h00, 0, 0, 0, 0, 1, 8'hBE, 0, 0);
        n(X, 8'h00, 0, 0, 0, 0, 1, 8'hEF, 0, 0);
        n(P, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(P, 8'h12, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        resp(8'h11, 8'h11, 0);
        // violation: bus_pc then bus_mar
        n(P, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h12, 0, 0, 0, 0, 0, 8'h00, 1, 0);
        n(X, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        // store to 0x12 killed by a double strobe in DATA_LO: memory untouched
        n(M, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 1);
        n(M, 8'h12, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        n(D, 8'h99, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        n(M | D, 8'h99, 0, 0, 0, 0, 0, 8'h00, 1, 1);
        n(X, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        n(P, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        n(P, 8'h12, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        resp(8'h11, 8'h11, 1);
        // bus_mdr alone in IDLE
        n(D, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1, 1);
        n(X, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        // strobe during RESP_HI: error but response continues
        n(P, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        n(P, 8'h03, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        n(X, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        n(X, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 1);
        n(P, 8'h00, 0, 0, 0, 0, 1, 8'h12, 1, 1);
        n(X, 8'h00, 0, 0, 0, 0, 1, 8'hAB, 0, 1);
        // reset in DATA_LO of a store to 0x07
        n(M, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 1);
        n(M, 8'h07, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        n(D, 8'h11, 0, 0, 0, 0, 0, 8'h00, 0, 1);
        add(1, D, 8'h22, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 0, 1);
        n(X, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(M, 8'h07, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        resp(8'h77, 8'h77, 0);
        // reset during RESP_HI suppresses the response
        n(P, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        n(P, 8'h12, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(X, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        n(X, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        add(1, X, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 0, 0);
        n(X, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0);

        foreach (q[i]) begin
            rst = q[i].rst;
            {bus_pc, bus_mar, bus_mdr} = q[i].stb;
            bus_data = q[i].data;
            req_store = q[i].st;
            req_byte = q[i].by;
            prog_we = q[i].pw;
            prog_addr = q[i].pa;
            prog_data = q[i].pd;
            @(negedge clk);
            chk("receive_ready", i, {15'd0, ard_receive_ready}, {15'd0, q[i].rr});
            chk("data_ready", i, {15'd0, ard_data_ready}, {15'd0, q[i].dr});
            chk("rsp_valid", i, {15'd0, rsp_valid}, {15'd0, q[i].rv});
            chk("rsp_data", i, {8'd0, rsp_data}, {8'd0, q[i].rd});
            chk("error", i, {15'd0, error}, {15'd0, q[i].er});
            chk("err_flag", i, {15'd0, err_flag}, {15'd0, q[i].ef});
            @(posedge clk);
            #1;
        end

        // latency measured with a bounded wait: fetch 0x0003 (0x12AB)
        {rst, bus_pc, bus_mar, bus_mdr, prog_we} = 5'b01000;
        bus_data = 8'h00;
        @(posedge clk);
        #1;
        bus_data = 8'h03;
        @(posedge clk);
        #1;
        bus_pc = 1'b0;
        k = 1;
        while (!ard_data_ready && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", 999, 16'(k), 16'd2);
        @(posedge clk);
        #1;
        chk("lat_hi", 999, {7'd0, rsp_valid, rsp_data}, {7'd0, 1'b1, 8'h12});
        @(posedge clk);
        #1;
        chk("lat_lo", 999, {7'd0, rsp_valid, rsp_data}, {7'd0, 1'b1, 8'hAB});
        @(posedge clk);
        #1;
        chk("lat_idle", 999, {15'd0, ard_receive_ready}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, 8, word-address width; memory depth is 2**ADDR_W 16-bit words.
REQ-002 SHALL have port clk  input  1  the single clock; all logic samples on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port bus_pc  input  1  the CPU is driving a PC byte on bus_data this cycle.
REQ-005 SHALL have port bus_mar  input  1  the CPU is driving a MAR byte on bus_data this cycle.
REQ-006 SHALL have port bus_mdr  input  1  the CPU is driving an MDR byte on bus_data this cycle.
REQ-007 SHALL have port bus_data  input  8  the request byte; the high byte is sent first.
REQ-008 SHALL have port req_store  input  1  the MAR transaction is a store; sampled on the first bus_mar beat.
REQ-009 SHALL have port req_byte  input  1  the store writes the low byte only; sampled on the first bus_mar beat.
REQ-010 SHALL have port prog_we  input  1  the preload write strobe.
REQ-011 SHALL have port prog_addr  input  ADDR_W  the preload word address.
REQ-012 SHALL have port prog_data  input  16  the preload word.
REQ-013 SHALL have port ard_receive_ready  output  1  the responder is idle and will accept a request.
REQ-014 SHALL have port ard_data_ready  output  1  a one-cycle pulse; the response bytes follow on the next two cycles.
REQ-015 SHALL have port rsp_valid  output  1  rsp_data holds a response byte this cycle.
REQ-016 SHALL have port rsp_data  output  8  the response byte, high byte first.
REQ-017 SHALL have port error  output  1  a one-cycle pulse on a protocol violation.
REQ-018 SHALL have port err_flag  output  1  a sticky error indicator, cleared only by rst.

Function
REQ-019 SHALL implement the states IDLE, PC_LO, MAR_LO, DATA_HI, DATA_LO, READ, RESP_RDY, RESP_HI, RESP_LO.
REQ-020 SHALL assert ard_receive_ready only in IDLE; every other output is 0 unless this section states otherwise.
REQ-021 SHALL flag more than one of bus_pc/bus_mar/bus_mdr high in any cycle as a violation.
REQ-022 SHALL, in IDLE on bus_pc alone, latch bus_data into addr[15:8] and go to PC_LO.
REQ-023 SHALL, in IDLE on bus_mar alone, latch addr[15:8], req_store and req_byte, then go to MAR_LO.
REQ-024 SHALL treat bus_mdr alone in IDLE as a violation and stay in IDLE; no strobe keeps the block in IDLE.
REQ-025 SHALL, in PC_LO, require bus_pc: latch addr[7:0] and go to READ.
REQ-026 SHALL, in MAR_LO, require bus_mar: latch addr[7:0], then go to DATA_HI if a store, else to READ.
REQ-027 SHALL, in DATA_HI, require bus_mdr: latch wdata[15:8] and go to DATA_LO.
REQ-028 SHALL, in DATA_LO, require bus_mdr: write the memory at the clock edge, then go to IDLE; a store produces no response.
REQ-029 SHALL write the word {wdata_hi, bus_data} for a full store; for a byte store (req_byte=1) only mem[15:8] stays unchanged and mem[7:0] takes the DATA_HI byte.
REQ-030 SHALL form the word index as addr[ADDR_W-1:0]; upper address bits are ignored, so addresses alias modulo the depth.
REQ-031 SHALL, in READ, register mem[index] into a response register and go to RESP_RDY.
REQ-032 SHALL, in RESP_RDY, assert ard_data_ready=1 and go to RESP_HI.
REQ-033 SHALL, in RESP_HI, assert rsp_valid=1 with rsp_data=resp[15:8] and go to RESP_LO.
REQ-034 SHALL, in RESP_LO, assert rsp_valid=1 with rsp_data=resp[7:0] and go to IDLE.
REQ-035 SHALL give a load or fetch the latency: last address beat at cycle N -> ard_data_ready at N+2 -> bytes at N+3 and N+4 -> ard_receive_ready at N+5.
REQ-036 SHALL handle a violation by pulsing error for one cycle, setting err_flag, discarding the partial request, going to IDLE, and leaving memory unwritten.
REQ-037 SHALL treat a missing or wrong strobe in PC_LO, MAR_LO, DATA_HI or DATA_LO as a violation.
REQ-038 SHALL treat any strobe in READ, RESP_RDY, RESP_HI or RESP_LO as a violation that pulses error and sets err_flag, while the response sequence continues unaffected.
REQ-039 SHALL let prog_we write mem[prog_addr]=prog_data in any state.
REQ-040 SHALL, when a prog_we and a DATA_LO store hit the same index in one cycle, keep the prog_data result.
REQ-041 SHALL, when the READ-cycle index equals a same-cycle prog_we index, return the old data (read-before-write).

Reset
REQ-042 SHALL, while rst=1, force the state to IDLE and clear addr, wdata, the response register and err_flag.
REQ-043 SHALL hold ard_data_ready=0, rsp_valid=0, rsp_data=8'h00 and error=0 during rst.
REQ-044 SHALL output ard_receive_ready=1 in the first cycle after rst deasserts.
REQ-045 SHALL abort any in-progress transaction on rst without writing memory and without emitting a response.
REQ-046 SHALL not reset memory contents.

Verification
REQ-047 SHALL pass the fetch test: preload mem[8'h12]=16'hBEEF, then send bus_pc bytes 8'h00, 8'h12 -> ard_data_ready 2 cycles after the second beat, then rsp_data 8'hBE, 8'hEF with rsp_valid.
REQ-048 SHALL pass the store/load test: bus_mar 8'h00, 8'h05 with req_store=1, then bus_mdr 8'hCA, 8'hFE -> no response; a load of 8'h0005 then returns 8'hCA, 8'hFE.
REQ-049 SHALL pass the byte-store test: with mem[3]=16'h1234, a req_byte store with data 8'hAB, 8'hxx -> a later load returns 8'h12, 8'hAB.
REQ-050 SHALL pass the violation test: bus_pc then bus_mar on consecutive cycles -> error pulses once, err_flag=1, ard_receive_ready=1 the next cycle, memory unchanged.
REQ-051 SHALL pass the reset test: assert rst in DATA_LO of a store to 8'h07 -> mem[7] unchanged, ard_receive_ready=1 after reset, err_flag=0.
REQ-052 SHALL pass the alias/collision test: with ADDR_W=8, a load of 16'h0112 returns mem[8'h12]; a same-cycle prog_we and store to one index leaves prog_data.
